// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_pkg
// Description : Shared forwarding encodings and register constants for the
//               five-stage pipeline hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        FWD_GPR = 2'd0,
        FWD_E   = 2'd1,
        FWD_M   = 2'd2,
        FWD_W   = 2'd3
    } fwd_sel_e;

    localparam logic [3:0] TUSE_NONE = 4'd5;
    localparam logic [4:0] ZERO_REG  = 5'd0;

    function automatic logic [3:0] tnew_dec(input logic [3:0] tnew);
        return (tnew == 4'd0) ? 4'd0 : tnew - 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stage_reg
// Description : One shadow pipeline stage: destination/rt record with
//               bubble-clear and saturating Tnew decrement on entry.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stage_reg
    import hazard_scoreboard_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_bubble,
    input  logic [4:0] i_a2,
    input  logic [4:0] i_a3,
    input  logic [3:0] i_tnew,
    input  logic       i_rw,
    output logic [4:0] o_a2,
    output logic [4:0] o_a3,
    output logic [3:0] o_tnew,
    output logic       o_rw
);

    logic [4:0] r_a2;
    logic [4:0] r_a3;
    logic [3:0] r_tnew;
    logic       r_rw;

    always_ff @(posedge clk) begin
        if (rst || i_bubble) begin
            r_a2   <= 5'd0;
            r_a3   <= 5'd0;
            r_tnew <= 4'd0;
            r_rw   <= 1'b0;
        end else begin
            r_a2   <= i_a2;
            r_a3   <= i_a3;
            r_tnew <= tnew_dec(i_tnew);
            r_rw   <= i_rw;
        end
    end

    assign o_a2   = r_a2;
    assign o_a3   = r_a3;
    assign o_tnew = r_tnew;
    assign o_rw   = r_rw;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : D-stage stall and D/E/M forwarding selects computed from a
//               shadow record of the E, M and W stage destinations.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter logic [4:0] ZERO_REG = hazard_scoreboard_pkg::ZERO_REG
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_A1,
    input  logic [4:0] D_A2,
    input  logic [4:0] D_A3,
    input  logic       D_Reg_Write,
    input  logic       D_A1use,
    input  logic       D_A2use,
    input  logic [3:0] D_rs_Tuse,
    input  logic [3:0] D_rt_Tuse,
    input  logic [3:0] D_Tnew,
    output logic       Stall,
    output logic [1:0] Fwd_D_rs,
    output logic [1:0] Fwd_D_rt,
    output logic [1:0] Fwd_E_rs,
    output logic [1:0] Fwd_E_rt,
    output logic [1:0] Fwd_M_rt
);
    import hazard_scoreboard_pkg::*;

    logic [4:0] r_e_a1;
    logic [4:0] w_e_a2, w_e_a3, w_m_a2, w_m_a3;
    logic [3:0] w_e_tnew, w_m_tnew;
    logic       w_e_rw, w_m_rw;
    logic [4:0] r_w_a3;
    logic       r_w_rw;

    // E.A1 is only needed for the E-stage rs forward, so it lives here.
    always_ff @(posedge clk) begin
        if (reset || Stall) begin
            r_e_a1 <= 5'd0;
        end else begin
            r_e_a1 <= D_A1;
        end
    end

    hazard_stage_reg u_stage_e (
        .clk      (clk),
        .rst      (reset),
        .i_bubble (Stall),
        .i_a2     (D_A2),
        .i_a3     (D_A3),
        .i_tnew   (D_Tnew),
        .i_rw     (D_Reg_Write),
        .o_a2     (w_e_a2),
        .o_a3     (w_e_a3),
        .o_tnew   (w_e_tnew),
        .o_rw     (w_e_rw)
    );

    hazard_stage_reg u_stage_m (
        .clk      (clk),
        .rst      (reset),
        .i_bubble (1'b0),
        .i_a2     (w_e_a2),
        .i_a3     (w_e_a3),
        .i_tnew   (w_e_tnew),
        .i_rw     (w_e_rw),
        .o_a2     (w_m_a2),
        .o_a3     (w_m_a3),
        .o_tnew   (w_m_tnew),
        .o_rw     (w_m_rw)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_w_a3 <= 5'd0;
            r_w_rw <= 1'b0;
        end else begin
            r_w_a3 <= w_m_a3;
            r_w_rw <= w_m_rw;
        end
    end

    logic w_e_hit_d1, w_e_hit_d2, w_m_hit_d1, w_m_hit_d2, w_w_hit_d1, w_w_hit_d2;
    logic w_m_hit_e1, w_m_hit_e2, w_w_hit_e1, w_w_hit_e2, w_w_hit_m2;

    assign w_e_hit_d1 = w_e_rw && (w_e_a3 == D_A1) && (D_A1 != ZERO_REG) && D_A1use;
    assign w_e_hit_d2 = w_e_rw && (w_e_a3 == D_A2) && (D_A2 != ZERO_REG) && D_A2use;
    assign w_m_hit_d1 = w_m_rw && (w_m_a3 == D_A1) && (D_A1 != ZERO_REG) && D_A1use;
    assign w_m_hit_d2 = w_m_rw && (w_m_a3 == D_A2) && (D_A2 != ZERO_REG) && D_A2use;
    assign w_w_hit_d1 = r_w_rw && (r_w_a3 == D_A1) && (D_A1 != ZERO_REG) && D_A1use;
    assign w_w_hit_d2 = r_w_rw && (r_w_a3 == D_A2) && (D_A2 != ZERO_REG) && D_A2use;

    assign w_m_hit_e1 = w_m_rw && (w_m_a3 == r_e_a1) && (r_e_a1 != ZERO_REG);
    assign w_m_hit_e2 = w_m_rw && (w_m_a3 == w_e_a2) && (w_e_a2 != ZERO_REG);
    assign w_w_hit_e1 = r_w_rw && (r_w_a3 == r_e_a1) && (r_e_a1 != ZERO_REG);
    assign w_w_hit_e2 = r_w_rw && (r_w_a3 == w_e_a2) && (w_e_a2 != ZERO_REG);
    assign w_w_hit_m2 = r_w_rw && (r_w_a3 == w_m_a2) && (w_m_a2 != ZERO_REG);

    logic w_rs_live, w_rt_live;
    assign w_rs_live = (D_rs_Tuse != TUSE_NONE);
    assign w_rt_live = (D_rt_Tuse != TUSE_NONE);

    assign Stall = (w_rs_live && w_e_hit_d1 && (D_rs_Tuse < w_e_tnew))
                || (w_rt_live && w_e_hit_d2 && (D_rt_Tuse < w_e_tnew))
                || (w_rs_live && w_m_hit_d1 && (D_rs_Tuse < w_m_tnew))
                || (w_rt_live && w_m_hit_d2 && (D_rt_Tuse < w_m_tnew));

    // Nearest hitting stage wins; if its value is not ready, no older stage
    // is consulted because the stall already holds the consumer.
    fwd_sel_e w_fwd_d_rs, w_fwd_d_rt, w_fwd_e_rs, w_fwd_e_rt, w_fwd_m_rt;

    always_comb begin
        w_fwd_d_rs = FWD_GPR;
        w_fwd_d_rt = FWD_GPR;
        w_fwd_e_rs = FWD_GPR;
        w_fwd_e_rt = FWD_GPR;
        w_fwd_m_rt = FWD_GPR;

        if (w_e_hit_d1)      w_fwd_d_rs = (w_e_tnew == 4'd0) ? FWD_E : FWD_GPR;
        else if (w_m_hit_d1) w_fwd_d_rs = (w_m_tnew == 4'd0) ? FWD_M : FWD_GPR;
        else if (w_w_hit_d1) w_fwd_d_rs = FWD_W;

        if (w_e_hit_d2)      w_fwd_d_rt = (w_e_tnew == 4'd0) ? FWD_E : FWD_GPR;
        else if (w_m_hit_d2) w_fwd_d_rt = (w_m_tnew == 4'd0) ? FWD_M : FWD_GPR;
        else if (w_w_hit_d2) w_fwd_d_rt = FWD_W;

        if (w_m_hit_e1)      w_fwd_e_rs = (w_m_tnew == 4'd0) ? FWD_M : FWD_GPR;
        else if (w_w_hit_e1) w_fwd_e_rs = FWD_W;

        if (w_m_hit_e2)      w_fwd_e_rt = (w_m_tnew == 4'd0) ? FWD_M : FWD_GPR;
        else if (w_w_hit_e2) w_fwd_e_rt = FWD_W;

        if (w_w_hit_m2)      w_fwd_m_rt = FWD_W;
    end

    assign Fwd_D_rs = w_fwd_d_rs;
    assign Fwd_D_rt = w_fwd_d_rt;
    assign Fwd_E_rs = w_fwd_e_rs;
    assign Fwd_E_rt = w_fwd_e_rt;
    assign Fwd_M_rt = w_fwd_m_rt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed instruction sequences with hand-computed stall and
//               forwarding expectations for hazard_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_A1, D_A2, D_A3;
    logic       D_Reg_Write, D_A1use, D_A2use;
    logic [3:0] D_rs_Tuse, D_rt_Tuse, D_Tnew;
    logic       Stall;
    logic [1:0] Fwd_D_rs, Fwd_D_rt, Fwd_E_rs, Fwd_E_rt, Fwd_M_rt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .D_A1        (D_A1),
        .D_A2        (D_A2),
        .D_A3        (D_A3),
        .D_Reg_Write (D_Reg_Write),
        .D_A1use     (D_A1use),
        .D_A2use     (D_A2use),
        .D_rs_Tuse   (D_rs_Tuse),
        .D_rt_Tuse   (D_rt_Tuse),
        .D_Tnew      (D_Tnew),
        .Stall       (Stall),
        .Fwd_D_rs    (Fwd_D_rs),
        .Fwd_D_rt    (Fwd_D_rt),
        .Fwd_E_rs    (Fwd_E_rs),
        .Fwd_E_rt    (Fwd_E_rt),
        .Fwd_M_rt    (Fwd_M_rt)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_stall"}, int'(Stall), 0);
        chk({tag, "_fdrs"}, int'(Fwd_D_rs), 0);
        chk({tag, "_fdrt"}, int'(Fwd_D_rt), 0);
        chk({tag, "_fers"}, int'(Fwd_E_rs), 0);
        chk({tag, "_fert"}, int'(Fwd_E_rt), 0);
        chk({tag, "_fmrt"}, int'(Fwd_M_rt), 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                         input logic rw, input logic u1, input logic u2,
                         input logic [3:0] ts, input logic [3:0] tt, input logic [3:0] tn);
        D_A1 = a1; D_A2 = a2; D_A3 = a3; D_Reg_Write = rw;
        D_A1use = u1; D_A2use = u2; D_rs_Tuse = ts; D_rt_Tuse = tt; D_Tnew = tn;
        #1;
    endtask

    task automatic nop();                                  set_d(0, 0, 0, 0, 0, 0, 5, 5, 0); endtask
    task automatic alu(input logic [4:0] rd, rs, rt);      set_d(rs, rt, rd, 1, 1, 1, 1, 1, 2); endtask
    task automatic ori(input logic [4:0] rt, rs);          set_d(rs, 0, rt, 1, 1, 0, 1, 5, 2); endtask
    task automatic lw(input logic [4:0] rt, base);         set_d(base, 0, rt, 1, 1, 0, 1, 5, 3); endtask
    task automatic sw(input logic [4:0] rt, base);         set_d(base, rt, 0, 0, 1, 1, 1, 2, 0); endtask
    task automatic beq(input logic [4:0] rs, rt);          set_d(rs, rt, 0, 0, 1, 1, 0, 0, 0); endtask
    task automatic jal();                                  set_d(0, 0, 31, 1, 0, 0, 5, 5, 1); endtask
    task automatic jr(input logic [4:0] rs);               set_d(rs, 0, 0, 0, 1, 0, 0, 5, 0); endtask

    task automatic flush();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1;
        nop();
        repeat (2) tick();
        reset = 1'b0;
        chk_quiet("reset");

        // add $1 -> beq $1,$0: one stall, then M forward
        alu(1, 2, 3);
        chk("add_nostall", int'(Stall), 0);
        tick();
        beq(1, 0);
        chk("beq_stall1", int'(Stall), 1);
        tick();
        chk("beq_stall_end", int'(Stall), 0);
        chk("beq_fwd_m", int'(Fwd_D_rs), 2);
        tick();
        flush();

        // lw $4 -> add $5,$4,$6
        lw(4, 9);
        tick();
        alu(5, 4, 6);
        chk("lwuse_stall", int'(Stall), 1);
        tick();
        chk("lwuse_stall_end", int'(Stall), 0);
        chk("lwuse_fdrs_notready", int'(Fwd_D_rs), 0);
        tick();
        nop();
        chk("lwuse_fers_w", int'(Fwd_E_rs), 3);
        flush();

        // lw $4 -> beq $4,$0: two stalls then W forward
        lw(4, 9);
        tick();
        beq(4, 0);
        chk("lwbeq_stall1", int'(Stall), 1);
        tick();
        chk("lwbeq_stall2", int'(Stall), 1);
        tick();
        chk("lwbeq_stall_end", int'(Stall), 0);
        chk("lwbeq_fwd_w", int'(Fwd_D_rs), 3);
        tick();
        flush();

        // jal -> jr $31: E forward; Tnew stays 0 into M (no wrap)
        jal();
        tick();
        jr(31);
        chk("jr_nostall", int'(Stall), 0);
        chk("jr_fwd_e", int'(Fwd_D_rs), 1);
        tick();
        alu(10, 31, 0);
        chk("jal_m_nostall", int'(Stall), 0);
        chk("jal_m_fwd", int'(Fwd_D_rs), 2);
        tick();
        flush();

        // $0 writer never hits
        ori(0, 2);
        tick();
        alu(7, 0, 0);
        chk_quiet("zero");
        tick();
        flush();

        // add $8 -> sw $8: E-hit not ready, then M, then W
        alu(8, 2, 3);
        tick();
        sw(8, 9);
        chk("sw_nostall", int'(Stall), 0);
        chk("sw_fdrt_notready", int'(Fwd_D_rt), 0);
        tick();
        nop();
        chk("sw_fert_m", int'(Fwd_E_rt), 2);
        tick();
        chk("sw_fmrt_w", int'(Fwd_M_rt), 3);
        flush();

        // reset in the middle of a lw-use stall
        lw(4, 9);
        tick();
        alu(5, 4, 6);
        chk("rst_pre_stall", int'(Stall), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk_quiet("rst_mid");
        tick();
        alu(11, 12, 13);
        chk("rst_indep_nostall", int'(Stall), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Pipeline hazard unit for the five-stage MIPS core: consumes the D-stage decode outputs (Tuse/Tnew, source/destination addresses, use flags, register-write enable) and keeps its own shadow record of the E, M and W stage destinations. From that record it produces the D-stage stall and the forwarding-mux selects for the D, E and M stages. It sits beside the datapath and receives the decoder output every cycle.

## Interface
Parameters:
- ZERO_REG, 5'd0: register never matched for stall or forward.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- D_A1  in  5  rs address of the instruction in D.
- D_A2  in  5  rt address of the instruction in D.
- D_A3  in  5  final write address of D instruction (after Reg_Dst/jal mux: rd, rt or 31).
- D_Reg_Write  in  1  D instruction writes the GPR file.
- D_A1use / D_A2use  in  1  rs/rt actually read.
- D_rs_Tuse / D_rt_Tuse  in  4  cycles until rs/rt are consumed; 5 means unused.
- D_Tnew  in  4  cycles until the result exists, counted from D (jal 1, ALU 2, lw 3, none 0).
- Stall  out  1  freeze PC and F/D, insert a bubble into D/E.
- Fwd_D_rs / Fwd_D_rt  out  2  0 = GPR, 1 = E stage, 2 = M stage, 3 = W stage.
- Fwd_E_rs / Fwd_E_rt  out  2  0 = pipeline register, 2 = M, 3 = W.
- Fwd_M_rt  out  2  0 = pipeline register, 3 = W.

## Operation
- Shadow stages: E {A1, A2, A3, Tnew, RW}, M {A2, A3, Tnew, RW}, W {A3, RW}.
- Tnew entering a stage is the previous value minus 1, saturating at 0:
  - E.Tnew = sat(D_Tnew−1).
  - M.Tnew = sat(E.Tnew−1).
- Stage X "hits" source S when all of these hold:
  - X.RW = 1.
  - X.A3 = S.
  - S ≠ ZERO_REG.
  - The corresponding use flag is 1 (D sources only).
- Stall is asserted when any of these hold:
  - E hits D_A1 and D_rs_Tuse < E.Tnew.
  - E hits D_A2 and D_rt_Tuse < E.Tnew.
  - M hits D_A1 and D_rs_Tuse < M.Tnew.
  - M hits D_A2 and D_rt_Tuse < M.Tnew.
  - Tuse = 5 never stalls.
- Forward selection picks the nearest hitting stage whose Tnew = 0, with priority E > M > W.
  - D sources may forward from E, M or W.
  - E sources may forward from M or W.
  - M rt may forward from W only.
  - W.Tnew is always 0.
  - If the nearest hitting stage has Tnew > 0, select 0 (stall covers it; no fall-through to an older stage).
- Update on each rising edge:
  - Normal: E ← D fields, M ← E, W ← M.
  - Stall: E ← bubble (all fields 0), M ← E, W ← M.

## Timing
- Stall and all Fwd_* are combinational from the current shadow state and D inputs; zero latency.
- Shadow state updates on the clk edge only.
- Reset: all shadow fields are 0, so Stall = 0 and every Fwd_* = 0 in the first cycle after reset.
- Reset asserted mid-stall clears the state; a pending stall is dropped, with no residual bubble.
- Simultaneous stall and forward: Fwd_* still reflects the current D instruction; the datapath ignores it while stalled.
- A bubble has RW = 0, so it never hits.
- Tnew saturates at 0 and never wraps.

## Structure
- Shared package constants:
  - Forward encodings FWD_GPR/FWD_E/FWD_M/FWD_W.
  - TUSE_NONE = 4'd5.
  - Register ZERO_REG.
- One sub-module, hazard_stage_reg: the per-stage shadow register with bubble-clear and saturating Tnew decrement, instanced for E and M. W is a plain register.
- Hit/priority logic stays in the top module.

## Test plan
- Sequence: add $1,$2,$3 → beq $1,$0 (rs_Tuse 0).
  - Stall = 1 for exactly one cycle.
  - Then Fwd_D_rs = 2 (M).
- Sequence: lw $4 → add $5,$4,$6.
  - One stall cycle.
  - Next cycle Stall = 0.
  - When add is in E, Fwd_E_rs = 3 (W).
- Sequence: lw $4 → beq $4,$0.
  - Stall = 1 for two cycles.
  - Then Fwd_D_rs = 3.
- Sequence: jal → jr $31.
  - No stall.
  - Fwd_D_rs = 1 (E, Tnew 0).
- Sequence: ori $0,… → add $7,$0,$0, and an add → sw rt chain.
  - For the $0 pair, Stall = 0 and all Fwd_* = 0.
  - sw in M gets Fwd_M_rt = 3.
- Reset asserted during a lw-use stall.
  - Next cycle Stall = 0 and all Fwd_* = 0.
  - A following independent add is not stalled.
